mem_arbiter: RTL and testbench

- Sequences all accesses to the single-port, byte-addressed main memory and shares it between the instruction-fetch port and the load/store data port.
- Arbitrates between the two requesters and registers every memory-side control signal.
- Implements byte and halfword stores as read-modify-write, because the memory only writes whole 32-bit words.
- Sits between the core's fetch/LSU and main_memory.

---
 rtl/mem_arbiter_pkg.sv | 34 +++
 rtl/mem_arbiter_store_merge.sv | 26 ++
 rtl/mem_arbiter.sv | 151 +++++++++++++++
 tb/tb_mem_arbiter.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared types and constants for the memory arbiter.
//   size_e  - load/store access size encoding (2'b11 is handled as a word)
//   state_e - one-hot arbiter states
//   owner_e - which requester owns the current memory access
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10
  } size_e;

  typedef enum logic [4:0] {
    ST_IDLE      = 5'b00001,
    ST_READ      = 5'b00010,
    ST_WRITE     = 5'b00100,
    ST_RMW_READ  = 5'b01000,
    ST_RMW_WRITE = 5'b10000
  } state_e;

  typedef enum logic {
    OWNER_INSTR = 1'b0,
    OWNER_DATA  = 1'b1
  } owner_e;

  // Clears the byte-lane bits of a byte address.
  localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

  // Byte and halfword stores need a read-modify-write; everything else is a word.
  function automatic logic is_subword(input logic [1:0] size);
    return (size == SIZE_BYTE) || (size == SIZE_HALF);
  endfunction

endpackage

// File: rtl/mem_arbiter_store_merge.sv
// store_merge: combinational merge of store data into an existing memory word.
//   old_word - word currently in memory
//   wdata    - right-aligned store data
//   size     - access size (byte / half / word; 2'b11 behaves as word)
//   lane     - byte address bits [1:0]; lane[0] is ignored for halfwords
//   new_word - word to write back
module store_merge
  import mem_arbiter_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  output logic [31:0] new_word
);

  always_comb begin
    new_word = old_word;
    case (size)
      SIZE_BYTE: new_word[{lane, 3'b000} +: 8]     = wdata[7:0];
      SIZE_HALF: new_word[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      default:   new_word = wdata;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single-port main memory between instruction fetch
// and the load/store unit, and turns byte/half stores into read-modify-write.
//   clk_i, rst_ni             - clock, asynchronous active-low reset
//   instr_req/addr/gnt/rvalid/rdata - fetch port (read only)
//   data_req/we/size/addr/wdata/gnt/rvalid/rdata - load/store port
//   mem_address/write_enable/write_value, mem_read_value_i - memory side;
//     the memory read is combinational, all memory controls are registered.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     instr_req_i,
  input  logic [ADDRESS_WIDTH-1:0] instr_addr_i,
  output logic                     instr_gnt_o,
  output logic                     instr_rvalid_o,
  output logic [DATA_WIDTH-1:0]    instr_rdata_o,
  input  logic                     data_req_i,
  input  logic                     data_we_i,
  input  logic [1:0]               data_size_i,
  input  logic [ADDRESS_WIDTH-1:0] data_addr_i,
  input  logic [DATA_WIDTH-1:0]    data_wdata_i,
  output logic                     data_gnt_o,
  output logic                     data_rvalid_o,
  output logic [DATA_WIDTH-1:0]    data_rdata_o,
  output logic [ADDRESS_WIDTH-1:0] mem_address_o,
  output logic                     mem_write_enable_o,
  output logic [DATA_WIDTH-1:0]    mem_write_value_o,
  input  logic [DATA_WIDTH-1:0]    mem_read_value_i
);

  state_e                   state_q, state_d;
  owner_e                   owner_q, last_owner_q, winner;
  logic                     grant;
  logic [ADDRESS_WIDTH-1:0] win_addr, win_addr_aligned;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [1:0]               lane_q;
  logic [1:0]               size_q;
  logic [DATA_WIDTH-1:0]    wval_q;
  logic [DATA_WIDTH-1:0]    merged;
  logic                     we_q;
  logic                     instr_rvalid_q, data_rvalid_q;
  logic [DATA_WIDTH-1:0]    instr_rdata_q, data_rdata_q;

  // wval_q holds the raw store data until RMW_READ, then the merged word.
  store_merge u_store_merge (
    .old_word (mem_read_value_i),
    .wdata    (wval_q),
    .size     (size_q),
    .lane     (lane_q),
    .new_word (merged)
  );

  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    winner  = last_owner_q;

    case (state_q)
      ST_IDLE: begin
        if (instr_req_i || data_req_i) begin
          grant = 1'b1;
          if (instr_req_i && data_req_i) begin
            winner = (last_owner_q == OWNER_INSTR) ? OWNER_DATA : OWNER_INSTR;
          end else begin
            winner = data_req_i ? OWNER_DATA : OWNER_INSTR;
          end
          if (winner == OWNER_INSTR || !data_we_i) begin
            state_d = ST_READ;
          end else if (is_subword(data_size_i)) begin
            state_d = ST_RMW_READ;
          end else begin
            state_d = ST_WRITE;
          end
        end
      end
      ST_RMW_READ: state_d = ST_RMW_WRITE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    win_addr         = (winner == OWNER_DATA) ? data_addr_i : instr_addr_i;
    win_addr_aligned = win_addr;
    win_addr_aligned[1:0] = win_addr[1:0] & WORD_ALIGN_MASK[1:0];
  end

  // Grants are combinational from the requests; gated by reset so every
  // output is 0 while rst_ni is low even if a requester is still asserting.
  assign instr_gnt_o = rst_ni & grant & (winner == OWNER_INSTR);
  assign data_gnt_o  = rst_ni & grant & (winner == OWNER_DATA);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= ST_IDLE;
      owner_q        <= OWNER_INSTR;
      last_owner_q   <= OWNER_INSTR;
      addr_q         <= '0;
      lane_q         <= '0;
      size_q         <= '0;
      wval_q         <= '0;
      we_q           <= 1'b0;
      instr_rvalid_q <= 1'b0;
      data_rvalid_q  <= 1'b0;
      instr_rdata_q  <= '0;
      data_rdata_q   <= '0;
    end else begin
      state_q <= state_d;
      // Write enable gets its own flop so the memory never sees a decode glitch.
      we_q    <= (state_d == ST_WRITE) || (state_d == ST_RMW_WRITE);

      instr_rvalid_q <= (state_q == ST_READ) && (owner_q == OWNER_INSTR);
      data_rvalid_q  <= (state_q == ST_READ) && (owner_q == OWNER_DATA);
      if (state_q == ST_READ) begin
        if (owner_q == OWNER_INSTR) begin
          instr_rdata_q <= mem_read_value_i;
        end else begin
          data_rdata_q <= mem_read_value_i;
        end
      end

      if (grant) begin
        owner_q      <= winner;
        last_owner_q <= winner;
        addr_q       <= win_addr_aligned;
        lane_q       <= win_addr[1:0];
        size_q       <= data_size_i;
        if (winner == OWNER_DATA && data_we_i) begin
          wval_q <= data_wdata_i;
        end
      end

      // Merge is done before the register so the write value is a flop output.
      if (state_q == ST_RMW_READ) begin
        wval_q <= merged;
      end
    end
  end

  assign instr_rvalid_o     = instr_rvalid_q;
  assign instr_rdata_o      = instr_rdata_q;
  assign data_rvalid_o      = data_rvalid_q;
  assign data_rdata_o       = data_rdata_q;
  assign mem_address_o      = addr_q;
  assign mem_write_enable_o = we_q;
  assign mem_write_value_o  = wval_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        instr_req_i;
  logic [31:0] instr_addr_i;
  logic        instr_gnt_o, instr_rvalid_o;
  logic [31:0] instr_rdata_o;
  logic        data_req_i, data_we_i;
  logic [1:0]  data_size_i;
  logic [31:0] data_addr_i, data_wdata_i;
  logic        data_gnt_o, data_rvalid_o;
  logic [31:0] data_rdata_o;
  logic [31:0] mem_address_o;
  logic        mem_write_enable_o;
  logic [31:0] mem_write_value_o;
  logic [31:0] mem_read_value_i;

  always #5 clk_i = ~clk_i;

  mem_arbiter #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk_i              (clk_i),
    .rst_ni             (rst_ni),
    .instr_req_i        (instr_req_i),
    .instr_addr_i       (instr_addr_i),
    .instr_gnt_o        (instr_gnt_o),
    .instr_rvalid_o     (instr_rvalid_o),
    .instr_rdata_o      (instr_rdata_o),
    .data_req_i         (data_req_i),
    .data_we_i          (data_we_i),
    .data_size_i        (data_size_i),
    .data_addr_i        (data_addr_i),
    .data_wdata_i       (data_wdata_i),
    .data_gnt_o         (data_gnt_o),
    .data_rvalid_o      (data_rvalid_o),
    .data_rdata_o       (data_rdata_o),
    .mem_address_o      (mem_address_o),
    .mem_write_enable_o (mem_write_enable_o),
    .mem_write_value_o  (mem_write_value_o),
    .mem_read_value_i   (mem_read_value_i)
  );

  // Standalone merge unit under test.
  logic [31:0] sm_old, sm_wdata, sm_new;
  logic [1:0]  sm_size, sm_lane;
  store_merge u_sm (
    .old_word (sm_old),
    .wdata    (sm_wdata),
    .size     (sm_size),
    .lane     (sm_lane),
    .new_word (sm_new)
  );

  function automatic logic [31:0] init_word(input int k);
    if (k == 4) return 32'hDEAD_BEEF;
    if (k >= 8 && k <= 16) return 32'h1122_3344;
    return 32'(k) * 32'h9E37_79B9 + 32'h0000_1357;
  endfunction

  // Memory: 64 words, combinational read, write on clock edge; reloaded in reset.
  logic [31:0] mem [0:63];
  assign mem_read_value_i = mem[mem_address_o[7:2]];
  always @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int k = 0; k < 64; k++) mem[k] <= init_word(k);
    end else if (mem_write_enable_o) begin
      mem[mem_address_o[7:2]] <= mem_write_value_o;
    end
  end

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [31:0] ref_mem [0:63];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, act, exp);
  endtask

  // Reference merge written as mask arithmetic on the whole word.
  function automatic logic [31:0] ref_merge(input logic [31:0] old, input logic [31:0] wd,
                                            input logic [1:0] size, input logic [1:0] lo);
    logic [31:0] mask;
    int sh;
    if (size == 2'b00) begin
      sh   = 8 * int'(lo);
      mask = 32'h0000_00FF << sh;
    end else if (size == 2'b01) begin
      sh   = lo[1] ? 16 : 0;
      mask = 32'h0000_FFFF << sh;
    end else begin
      return wd;
    end
    return (old & ~mask) | ((wd << sh) & mask);
  endfunction

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    @(negedge clk_i);
  endtask

  task automatic idle_inputs();
    instr_req_i  = 1'b0;
    instr_addr_i = '0;
    data_req_i   = 1'b0;
    data_we_i    = 1'b0;
    data_size_i  = 2'b00;
    data_addr_i  = '0;
    data_wdata_i = '0;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    idle_inputs();
    for (int k = 0; k < 64; k++) ref_mem[k] = init_word(k);
    repeat (2) @(posedge clk_i);
    settle();
    chk("rst_ctrl", 32'({instr_gnt_o, instr_rvalid_o, data_gnt_o, data_rvalid_o,
                         mem_write_enable_o}), 32'd0);
    chk("rst_addr", mem_address_o, 32'd0);
    chk("rst_wval", mem_write_value_o, 32'd0);
    chk("rst_rdata", instr_rdata_o | data_rdata_o, 32'd0);
    next_cycle();
    rst_ni = 1'b1;
  endtask

  task automatic store_req(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] wd);
    data_req_i   = 1'b1;
    data_we_i    = 1'b1;
    data_size_i  = size;
    data_addr_i  = addr;
    data_wdata_i = wd;
  endtask

  // Sub-word store: grant at cycle 0, single write pulse at cycle 2.
  task automatic sub_store(input string tag, input logic [31:0] addr, input logic [1:0] size,
                           input logic [31:0] wd, input logic [31:0] exp_addr,
                           input logic [31:0] exp_val);
    do_reset();
    store_req(addr, size, wd);
    settle();
    chk({tag, "_gnt"}, 32'(data_gnt_o), 32'd1);
    next_cycle();
    idle_inputs();
    settle();
    chk({tag, "_we_c1"}, 32'(mem_write_enable_o), 32'd0);
    next_cycle();
    settle();
    chk({tag, "_we_c2"}, 32'(mem_write_enable_o), 32'd1);
    chk({tag, "_addr"}, mem_address_o, exp_addr);
    chk({tag, "_val"}, mem_write_value_o, exp_val);
    next_cycle();
    settle();
    chk({tag, "_we_c3"}, 32'(mem_write_enable_o), 32'd0);
    next_cycle();
  endtask

  int          win, last, free_at, exp_iv, exp_dv, exp_we, idx;
  logic        ip, dp;
  logic [31:0] exp_ird, exp_drd, exp_wa, exp_wv;

  initial begin
    rst_ni = 1'b0;
    idle_inputs();

    // store_merge on its own
    for (int i = 0; i < 48; i++) begin
      sm_old   = $urandom;
      sm_wdata = $urandom;
      sm_size  = 2'($urandom_range(0, 3));
      sm_lane  = 2'($urandom_range(0, 3));
      #1;
      chk("sm_merge", sm_new, ref_merge(sm_old, sm_wdata, sm_size, sm_lane));
    end

    // Fetch of 0x10
    do_reset();
    instr_req_i  = 1'b1;
    instr_addr_i = 32'h0000_0010;
    settle();
    chk("t1_ignt", 32'(instr_gnt_o), 32'd1);
    chk("t1_dgnt", 32'(data_gnt_o), 32'd0);
    next_cycle();
    idle_inputs();
    settle();
    chk("t1_rv_c1", 32'(instr_rvalid_o), 32'd0);
    chk("t1_addr", mem_address_o, 32'h0000_0010);
    chk("t1_we_c1", 32'(mem_write_enable_o), 32'd0);
    next_cycle();
    settle();
    chk("t1_rv_c2", 32'(instr_rvalid_o), 32'd1);
    chk("t1_rdata", instr_rdata_o, 32'hDEAD_BEEF);
    chk("t1_we_c2", 32'(mem_write_enable_o), 32'd0);
    next_cycle();
    settle();
    chk("t1_rv_c3", 32'(instr_rvalid_o), 32'd0);
    next_cycle();

    // Both requesters held: DATA, INSTR, DATA, INSTR
    do_reset();
    instr_req_i = 1'b1;
    instr_addr_i = 32'h0000_0010;
    data_req_i  = 1'b1;
    data_addr_i = 32'h0000_0020;
    for (int c = 0; c < 8; c++) begin
      settle();
      chk("t2_ignt", 32'(instr_gnt_o), (c % 4 == 2) ? 32'd1 : 32'd0);
      chk("t2_dgnt", 32'(data_gnt_o), (c % 4 == 0) ? 32'd1 : 32'd0);
      if (c == 2) chk("t2_drdata", data_rdata_o, 32'h1122_3344);
      if (c == 4) chk("t2_irdata", instr_rdata_o, 32'hDEAD_BEEF);
      next_cycle();
    end
    idle_inputs();

    // Sub-word stores
    sub_store("t3_byte", 32'h0000_0022, 2'b00, 32'h0000_00AB, 32'h0000_0020, 32'h11AB_3344);
    sub_store("t4_half36", 32'h0000_0036, 2'b01, 32'h0000_BEEF, 32'h0000_0034, 32'hBEEF_3344);
    sub_store("t4_half35", 32'h0000_0035, 2'b01, 32'h0000_BEEF, 32'h0000_0034, 32'h1122_BEEF);

    // Word store then load back
    do_reset();
    store_req(32'h0000_0043, 2'b10, 32'hCAFE_F00D);
    settle();
    chk("t5_gnt", 32'(data_gnt_o), 32'd1);
    next_cycle();
    idle_inputs();
    settle();
    chk("t5_we_c1", 32'(mem_write_enable_o), 32'd1);
    chk("t5_addr", mem_address_o, 32'h0000_0040);
    chk("t5_val", mem_write_value_o, 32'hCAFE_F00D);
    next_cycle();
    data_req_i  = 1'b1;
    data_size_i = 2'b10;
    data_addr_i = 32'h0000_0040;
    settle();
    chk("t5_we_c2", 32'(mem_write_enable_o), 32'd0);
    chk("t5_ld_gnt", 32'(data_gnt_o), 32'd1);
    next_cycle();
    idle_inputs();
    settle();
    next_cycle();
    settle();
    chk("t5_ld_rv", 32'(data_rvalid_o), 32'd1);
    chk("t5_ld_data", data_rdata_o, 32'hCAFE_F00D);
    next_cycle();

    // Reset in the middle of RMW_WRITE
    do_reset();
    store_req(32'h0000_0022, 2'b00, 32'h0000_00AB);
    settle();
    next_cycle();
    idle_inputs();
    settle();
    next_cycle();
    settle();
    chk("t6_we_pre", 32'(mem_write_enable_o), 32'd1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("t6_we_async", 32'(mem_write_enable_o), 32'd0);
    chk("t6_addr_async", mem_address_o, 32'd0);
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    for (int k = 0; k < 64; k++) ref_mem[k] = init_word(k);
    for (int c = 0; c < 3; c++) begin
      settle();
      chk("t6_no_rv", 32'({instr_rvalid_o, data_rvalid_o, mem_write_enable_o}), 32'd0);
      next_cycle();
    end
    instr_req_i  = 1'b1;
    instr_addr_i = 32'h0000_0020;
    settle();
    chk("t6_idle_gnt", 32'(instr_gnt_o), 32'd1);
    next_cycle();
    idle_inputs();
    next_cycle();
    settle();
    chk("t6_rdata", instr_rdata_o, 32'h1122_3344);
    next_cycle();

    // Randomized traffic against a transaction-level model
    do_reset();
    last = 0; free_at = 0; exp_iv = -1; exp_dv = -1; exp_we = -1;
    ip = 1'b0; dp = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!ip && cyc < 2980 && $urandom_range(0, 2) == 0) begin
        ip = 1'b1;
        instr_addr_i = 32'($urandom_range(0, 255));
      end
      if (!dp && cyc < 2980 && $urandom_range(0, 2) == 0) begin
        dp = 1'b1;
        data_we_i    = 1'($urandom_range(0, 1));
        data_size_i  = 2'($urandom_range(0, 3));
        data_addr_i  = 32'($urandom_range(0, 255));
        data_wdata_i = $urandom;
      end
      instr_req_i = ip;
      data_req_i  = dp;
      settle();

      win = -1;
      if (cyc >= free_at && (ip || dp)) begin
        if (ip && dp) win = (last == 0) ? 1 : 0;
        else          win = dp ? 1 : 0;
      end
      chk("rnd_ignt", 32'(instr_gnt_o), (win == 0) ? 32'd1 : 32'd0);
      chk("rnd_dgnt", 32'(data_gnt_o), (win == 1) ? 32'd1 : 32'd0);
      chk("rnd_irv", 32'(instr_rvalid_o), (cyc == exp_iv) ? 32'd1 : 32'd0);
      if (cyc == exp_iv) chk("rnd_irdata", instr_rdata_o, exp_ird);
      chk("rnd_drv", 32'(data_rvalid_o), (cyc == exp_dv) ? 32'd1 : 32'd0);
      if (cyc == exp_dv) chk("rnd_drdata", data_rdata_o, exp_drd);
      chk("rnd_we", 32'(mem_write_enable_o), (cyc == exp_we) ? 32'd1 : 32'd0);
      if (cyc == exp_we) begin
        chk("rnd_waddr", mem_address_o, exp_wa);
        chk("rnd_wval", mem_write_value_o, exp_wv);
      end

      if (win == 0) begin
        last    = 0;
        ip      = 1'b0;
        exp_iv  = cyc + 2;
        exp_ird = ref_mem[instr_addr_i[7:2]];
        free_at = cyc + 2;
      end else if (win == 1) begin
        last = 1;
        dp   = 1'b0;
        idx  = int'(data_addr_i[7:2]);
        if (!data_we_i) begin
          exp_dv  = cyc + 2;
          exp_drd = ref_mem[idx];
          free_at = cyc + 2;
        end else begin
          exp_wa = data_addr_i & ~32'd3;
          exp_wv = ref_merge(ref_mem[idx], data_wdata_i, data_size_i, data_addr_i[1:0]);
          ref_mem[idx] = exp_wv;
          if (data_size_i >= 2'b10) begin
            exp_we  = cyc + 1;
            free_at = cyc + 2;
          end else begin
            exp_we  = cyc + 2;
            free_at = cyc + 3;
          end
        end
      end
      next_cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
